// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pulls words from the read side of a FIFO and presents them
// as a valid/ready stream grouped into PKT_LEN-word packets. A 2-entry
// in-order buffer absorbs the one-cycle FIFO read latency. Reads are issued
// only when buffered plus in-flight words, less the word leaving this cycle,
// leave room, so the buffer can never overflow.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                  r_clk,
  input  logic                  r_rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [15:0]           pkt_count
);

  localparam int              BW       = $clog2(PKT_LEN);
  localparam logic [BW-1:0]   BEAT_MAX = BW'(PKT_LEN - 1);

  // Buffer: head is the word on m_data, tail is the word behind it.
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [15:0]           pkt_q, pkt_d;
  // Set on the first clock edge after reset release; holds off reads until then.
  logic                  run_q, run_d;

  logic                  pop_s;
  logic [1:0]            committed_s;
  logic                  rd_en_s;

  // Read request: room exists once this cycle's pop is accounted for.
  always_comb begin
    pop_s       = (occ_q != 2'd0) && m_ready;
    committed_s = occ_q + {1'b0, inflight_q} - {1'b0, pop_s};
    rd_en_s     = run_q && !fifo_empty && (committed_s < 2'd2);
    inflight_d  = rd_en_s;
    run_d       = 1'b1;
  end

  // Buffer update: capture the in-flight word at the tail, shift on pop.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({inflight_q, pop_s})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = fifo_rd_data;
        end else begin
          tail_d = fifo_rd_data;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = fifo_rd_data;
        end else begin
          head_d = tail_q;
          tail_d = fifo_rd_data;
        end
      end
      default: begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
      end
    endcase
  end

  // Beat position within the packet and completed-packet counter.
  always_comb begin
    beat_d = beat_q;
    pkt_d  = pkt_q;
    if (pop_s) begin
      if (beat_q == BEAT_MAX) begin
        beat_d = {BW{1'b0}};
        pkt_d  = pkt_q + 16'd1;
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end else begin
      beat_d = beat_q;
    end
  end

  // State registers; reset discards buffered and in-flight words.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      head_q     <= {DATA_WIDTH{1'b0}};
      tail_q     <= {DATA_WIDTH{1'b0}};
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= {BW{1'b0}};
      pkt_q      <= 16'd0;
      run_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
      pkt_q      <= pkt_d;
      run_q      <= run_d;
    end
  end

  assign fifo_rd_en = rd_en_s;
  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = head_q;
  assign m_last     = (occ_q != 2'd0) && (beat_q == BEAT_MAX);
  assign pkt_count  = pkt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a behavioural FIFO source feeds the DUT; every word
// handed to the source pushes its expected stream word (data, last flag,
// packet count at that point) into a scoreboard that a separate monitor pops.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int PL = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [15:0]   pkts;
  } exp_t;

  logic          r_clk = 1'b0;
  logic          r_rst_n;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [15:0]   pkt_count;

  always #5 r_clk = ~r_clk;

  fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
    .r_clk        (r_clk),
    .r_rst_n      (r_rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .pkt_count    (pkt_count)
  );

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] src_q[$];
  exp_t          exp_q[$];
  int            push_idx = 0;
  int            rd_cnt   = 0;
  int            pop_cnt  = 0;
  logic          rd_s;
  logic          valid_s;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Monitor: pops the scoreboard on every accepted word and checks stream rules.
  int            outstanding = 0;
  bit            prev_stall  = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  exp_t          mon_e;
  always @(negedge r_clk) begin
    if (!r_rst_n) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        rd_cnt++;
        check_eq("rd_while_empty", fifo_empty, 1'b0);
      end
      if (prev_stall) begin
        check_eq("stall_valid", m_valid, 1'b1);
        check_eq("stall_data", m_data, prev_data);
        check_eq("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        pop_cnt++;
        check_eq("word_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_eq("m_data", m_data, mon_e.data);
          check_eq("m_last", m_last, mon_e.last);
          check_eq("pkt_count", pkt_count, mon_e.pkts);
        end
      end
      outstanding = outstanding + int'(fifo_rd_en) - int'(m_valid && m_ready);
      check_eq("no_overflow", outstanding <= 2, 1'b1);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // One clock: sample read strobe mid-cycle, then model the FIFO after the edge.
  task automatic step();
    @(negedge r_clk);
    rd_s    = fifo_rd_en;
    valid_s = m_valid;
    @(posedge r_clk);
    #1;
    if (rd_s && src_q.size() > 0) fifo_rd_data = src_q.pop_front();
    else fifo_rd_data = DW'($urandom);
    fifo_empty = (src_q.size() == 0);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    exp_t e;
    src_q.push_back(w);
    e.data = w;
    e.last = ((push_idx % PL) == PL - 1);
    e.pkts = 16'(push_idx / PL);
    exp_q.push_back(e);
    push_idx++;
    fifo_empty = 1'b0;
  endtask

  // The FIFO read side shares the reset, so its contents go too.
  task automatic assert_reset();
    r_rst_n = 1'b0;
    src_q.delete();
    exp_q.delete();
    push_idx   = 0;
    fifo_empty = 1'b1;
  endtask

  task automatic reset_cycle();
    assert_reset();
    step();
    step();
    r_rst_n = 1'b1;
  endtask

  // Waits (bounded) for m_valid, then counts consecutive valid cycles.
  task automatic count_run(output int run);
    int waited;
    waited = 0;
    run    = 0;
    step();
    while (!valid_s && waited < 20) begin
      step();
      waited++;
    end
    while (valid_s && run < 64) begin
      run++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  int run;
  int r0;
  int p0;
  int waited;

  initial begin
    r_rst_n      = 1'b0;
    m_ready      = 1'b1;
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;

    // Reset with a non-empty FIFO and a ready sink
    assert_reset();
    push_word(8'h01);
    step();
    check_eq("rst_rd_en", fifo_rd_en, 1'b0);
    check_eq("rst_valid", m_valid, 1'b0);
    check_eq("rst_data", m_data, 8'h00);
    check_eq("rst_last", m_last, 1'b0);
    check_eq("rst_pkt_count", pkt_count, 16'd0);
    r_rst_n = 1'b1;
    step();
    check_eq("rd_before_first_edge", rd_s, 1'b0);

    // Single word
    r0 = rd_cnt;
    count_run(run);
    check_eq("single_run", run, 1);
    repeat (3) step();
    check_eq("single_reads", rd_cnt - r0, 1);

    // Streaming two packets
    reset_cycle();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    count_run(run);
    check_eq("stream_run", run, 8);
    step();
    check_eq("stream_pkts", pkt_count, 16'd2);

    // Backpressure
    reset_cycle();
    m_ready = 1'b0;
    r0 = rd_cnt;
    for (int i = 1; i <= 6; i++) push_word(DW'(i));
    repeat (10) step();
    check_eq("bp_reads", rd_cnt - r0, 2);
    check_eq("bp_valid", m_valid, 1'b1);
    check_eq("bp_data", m_data, 8'h01);
    m_ready = 1'b1;
    count_run(run);
    check_eq("bp_release_run", run, 6);

    // FIFO empties mid-packet
    reset_cycle();
    m_ready = 1'b1;
    push_word(8'h01);
    push_word(8'h02);
    count_run(run);
    check_eq("empty_run_a", run, 2);
    r0 = rd_cnt;
    repeat (5) step();
    check_eq("empty_no_reads", rd_cnt - r0, 0);
    check_eq("empty_valid_low", m_valid, 1'b0);
    push_word(8'h03);
    push_word(8'h04);
    count_run(run);
    check_eq("empty_run_b", run, 2);
    step();
    check_eq("empty_pkts", pkt_count, 16'd1);

    // Reset mid-packet with a word in flight
    reset_cycle();
    m_ready = 1'b1;
    for (int i = 1; i <= 6; i++) push_word(DW'(i));
    p0 = pop_cnt;
    waited = 0;
    while (pop_cnt - p0 < 2 && waited < 20) begin
      step();
      waited++;
    end
    check_eq("mid_pops", pop_cnt - p0, 2);
    check_eq("mid_inflight", rd_s, 1'b1);
    assert_reset();
    #1;
    check_eq("mid_rst_valid", m_valid, 1'b0);
    check_eq("mid_rst_last", m_last, 1'b0);
    check_eq("mid_rst_data", m_data, 8'h00);
    check_eq("mid_rst_pkts", pkt_count, 16'd0);
    check_eq("mid_rst_rd_en", fifo_rd_en, 1'b0);
    step();
    step();
    r_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'h11 + 8'(i));
    count_run(run);
    check_eq("mid_after_run", run, 4);
    step();
    check_eq("mid_after_pkts", pkt_count, 16'd1);

    // Randomized traffic with varying sink readiness
    reset_cycle();
    for (int i = 0; i < 3000; i++) begin
      step();
      case ((i / 500) % 3)
        0:       m_ready = ($urandom_range(0, 3) != 0);
        1:       m_ready = ($urandom_range(0, 3) == 0);
        default: m_ready = 1'b1;
      endcase
      if (src_q.size() < 8 && $urandom_range(0, 2) != 0) push_word(DW'($urandom));
    end
    m_ready = 1'b1;
    waited  = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0) && waited < 50) begin
      step();
      waited++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
    check_eq("drain_pkts", pkt_count, 16'(push_idx / PL));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
